// File: rtl/regwatch_pkg.sv
// Shared types and constants for the regwatch register-file watch/self-check unit.
package regwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regwatch_shadow.sv
// Shadow copy of architectural registers x1..x(NUM_WATCH-1), fed by the writeback snoop.
// x0 has no storage and always reads zero; two independent combinational read ports.
module regwatch_shadow
  import regwatch_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NUM_WATCH = 10,
  parameter int IDX_W     = idx_width(NUM_WATCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [IDX_W-1:0]      chk_idx,
  output logic [XLEN-1:0]       chk_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [XLEN-1:0]       rd_data
);

  logic [XLEN-1:0] mem_q [1:NUM_WATCH-1];
  logic [XLEN-1:0] mem_d [1:NUM_WATCH-1];

  // Addresses outside 1..NUM_WATCH-1 match no entry and are simply not stored.
  always_comb begin
    mem_d = mem_q;
    for (int i = 1; i < NUM_WATCH; i++) begin
      if (wb_en && (wb_addr == REG_ADDR_W'(i))) mem_d[i] = wb_data;
    end
  end

  always_comb begin
    chk_data = '0;
    rd_data  = '0;
    for (int i = 1; i < NUM_WATCH; i++) begin
      if (chk_idx == IDX_W'(i)) chk_data = mem_q[i];
      if (rd_idx == IDX_W'(i))  rd_data  = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

endmodule

// File: rtl/regwatch_checker.sv
// Register-file watch and self-check unit: snoops writeback, detects the halt write,
// then compares the shadow against a loaded expected table. Optional macro: REGWATCH_RETIRE_CNT_EN.
module regwatch_checker
  import regwatch_pkg::*;
#(
  parameter int              XLEN           = XLEN_DEFAULT,
  parameter int              NUM_WATCH      = 10,
  parameter int              HALT_REG       = 31,
  parameter logic [XLEN-1:0] HALT_VALUE     = XLEN'(32'h0000_0001),
  parameter int              TIMEOUT_CYCLES = 10000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wb_en,
  input  logic [REG_ADDR_W-1:0]              wb_addr,
  input  logic [XLEN-1:0]                    wb_data,
  input  logic                               exp_we,
  input  logic [idx_width(NUM_WATCH)-1:0]    exp_idx,
  input  logic [XLEN-1:0]                    exp_data,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [$clog2(NUM_WATCH+1)-1:0]     mismatch_cnt,
  output logic [idx_width(NUM_WATCH)-1:0]    first_fail_idx,
  output logic [31:0]                        cycle_cnt,
  output logic [31:0]                        retire_cnt,
  input  logic [idx_width(NUM_WATCH)-1:0]    rd_idx,
  output logic [XLEN-1:0]                    rd_data,
  output state_e                             dbg_state
);

  localparam int IDX_W = idx_width(NUM_WATCH);
  localparam int CNT_W = $clog2(NUM_WATCH + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic [CNT_W-1:0] mm_q, mm_d;
  logic [31:0]      cycle_q, cycle_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-1:0]  exp_q [NUM_WATCH];
  logic [XLEN-1:0]  exp_d [NUM_WATCH];
  logic [NUM_WATCH-1:0] vld_q, vld_d;

  logic             ctrl_idle, start_ok, halt, entry_bad;
  logic [XLEN-1:0]  chk_data;

  // wb_* is a valid-only snoop: no backpressure, every cycle with wb_en high is one writeback.
  regwatch_shadow #(
    .XLEN      (XLEN),
    .NUM_WATCH (NUM_WATCH),
    .IDX_W     (IDX_W)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .chk_idx  (chk_idx_q),
    .chk_data (chk_data),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  assign ctrl_idle = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok  = start && ctrl_idle;
  assign halt      = wb_en && (wb_addr == REG_ADDR_W'(HALT_REG)) && (wb_data == HALT_VALUE);
  assign entry_bad = vld_q[chk_idx_q] && (chk_data != exp_q[chk_idx_q]);

  always_comb begin
    state_d   = state_q;
    chk_idx_d = chk_idx_q;
    ffi_d     = ffi_q;
    mm_d      = mm_q;
    cycle_d   = cycle_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    exp_d     = exp_q;
    vld_d     = vld_q;

    for (int i = 0; i < NUM_WATCH; i++) begin
      if (ctrl_idle && exp_we && (exp_idx == IDX_W'(i))) begin
        exp_d[i] = exp_data;
        vld_d[i] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d   = ST_RUN;
          chk_idx_d = '0;
          ffi_d     = '0;
          mm_d      = '0;
          cycle_d   = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_RUN: begin
        // A halt on the last budgeted cycle still wins over the timeout.
        if (halt) begin
          state_d   = ST_CHECK;
          chk_idx_d = '0;
          cycle_d   = cycle_q + 32'd1;
        end else if (cycle_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          cycle_d   = cycle_q + 32'd1;
        end
      end
      ST_CHECK: begin
        if (entry_bad) begin
          mm_d = mm_q + CNT_W'(1);
          if (mm_q == '0) ffi_d = chk_idx_q;
        end
        if (chk_idx_q == IDX_W'(NUM_WATCH - 1)) begin
          state_d   = ST_DONE;
          pass_d    = (mm_d == '0);
          timeout_d = 1'b0;
        end else begin
          chk_idx_d = chk_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      chk_idx_q <= '0;
      ffi_q     <= '0;
      mm_q      <= '0;
      cycle_q   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      exp_q     <= '{default: '0};
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      chk_idx_q <= chk_idx_d;
      ffi_q     <= ffi_d;
      mm_q      <= mm_d;
      cycle_q   <= cycle_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      exp_q     <= exp_d;
      vld_q     <= vld_d;
    end
  end

`ifdef REGWATCH_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (start_ok)                                            retire_d = '0;
    else if ((state_q == ST_RUN) && wb_en && (retire_q != '1)) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = '0;
`endif

  assign busy           = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign mismatch_cnt   = mm_q;
  assign first_fail_idx = ffi_q;
  assign cycle_cnt      = cycle_q;
  assign dbg_state      = state_q;

endmodule
